spart_rx_intf: RTL and testbench

Processor-side receive interface for the SPART. Sits directly downstream of the UART receiver: takes each received byte (`rx_data` qualified by `rdy`), acknowledges it with `clr_rdy`, and queues it in a small FIFO. The processor drains the FIFO over the 2-bit-address I/O bus. The block also owns the 13-bit baud divisor register that drives the receiver's `baud_rate` input, plus status and overrun reporting.

---
 rtl/spart_pkg.sv | 24 ++
 rtl/spart_rx_intf_if.sv | 18 +
 rtl/spart_rx_intf_sync_fifo.sv | 59 +++++
 rtl/spart_rx_intf.sv | 123 ++++++++++++
 tb/tb_spart_rx_intf.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART receive interface.
//   BAUD_W        width of the baud divisor
//   ADDR_*        I/O bus register addresses
//   cap_state_t   receiver capture FSM states
//   pack_status   builds the status register byte
package spart_pkg;

   localparam int unsigned BAUD_W = 13;

   localparam logic [1:0] ADDR_RXD  = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DBL  = 2'b10;
   localparam logic [1:0] ADDR_DBH  = 2'b11;

   typedef enum logic {
      CAP_IDLE,
      CAP_WAIT
   } cap_state_t;

   function automatic logic [7:0] pack_status(input logic ovr, input logic [4:0] cnt);
      return {2'b00, ovr, cnt};
   endfunction

endpackage

// File: rtl/spart_rx_intf_if.sv
// Processor I/O bus of the SPART receive interface.
//   iocs    chip select for an access this cycle
//   iorw    1 = read, 0 = write
//   ioaddr  register select
//   wdata   write data
//   rdata   read data (combinational)
//   rda     receive data available
interface spart_rx_intf_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       rda;

   modport master (output iocs, iorw, ioaddr, wdata, input rdata, rda);
   modport slave  (input iocs, iorw, ioaddr, wdata, output rdata, rda);
endinterface

// File: rtl/spart_rx_intf_sync_fifo.sv
// Synchronous circular FIFO with first-word fall-through output.
//   clk, rst  clock, synchronous active-high reset
//   push      write din (accepted when not full, or when a pop frees a slot)
//   pop       advance head (ignored when empty)
//   din/dout  write data / head of queue
//   full, empty, count (0..DEPTH)
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = mem[rd_ptr];

   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spart_rx_intf.sv
// Processor-side receive interface of the SPART: captures bytes from the
// UART receiver into a FIFO, serves them on the I/O bus, and owns the baud
// divisor and overrun flag.
//   clk, rst   clock, synchronous active-high reset
//   bus        processor I/O bus (slave side)
//   rx_data    byte from the receiver, qualified by rdy
//   rdy        receiver byte-valid (level or pulse)
//   clr_rdy    registered one-cycle acknowledge to the receiver
//   baud_rate  divisor driven to the receiver
//   overrun    sticky: a byte was dropped on a full FIFO
module spart_rx_intf
   import spart_pkg::*;
#(
   parameter int unsigned        DEPTH        = 8,
   parameter logic [BAUD_W-1:0]  BAUD_DEFAULT = 13'd5208
) (
   input  logic               clk,
   input  logic               rst,
   spart_rx_intf_if.slave     bus,
   input  logic [7:0]         rx_data,
   input  logic               rdy,
   output logic               clr_rdy,
   output logic [BAUD_W-1:0]  baud_rate,
   output logic               overrun
);

   localparam int unsigned CW = $clog2(DEPTH+1);

   cap_state_t     state_q;
   cap_state_t     state_d;
   logic           capture;
   logic           drop;
   logic           rd_en;
   logic           wr_en;
   logic           pop_req;
   logic [7:0]     fifo_dout;
   logic           fifo_full;
   logic           fifo_empty;
   logic [CW-1:0]  fifo_count;

   assign rd_en   = bus.iocs &  bus.iorw;
   assign wr_en   = bus.iocs & ~bus.iorw;
   assign pop_req = rd_en & (bus.ioaddr == ADDR_RXD);

   // A full FIFO still accepts the byte if a pop happens in the same cycle.
   assign drop = capture & fifo_full & ~pop_req;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (capture),
      .pop   (pop_req),
      .din   (rx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Capture FSM: one push per rdy assertion regardless of its length.
   always_ff @(posedge clk) begin
      if (rst) state_q <= CAP_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         CAP_IDLE: begin
            if (rdy) begin
               capture = 1'b1;
               state_d = CAP_WAIT;
            end
         end
         CAP_WAIT: begin
            if (!rdy) state_d = CAP_IDLE;
         end
         default: state_d = CAP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) clr_rdy <= 1'b0;
      else     clr_rdy <= capture;
   end

   // Baud halves load independently; software writes both.
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_rate <= BAUD_DEFAULT;
      end else if (wr_en) begin
         if (bus.ioaddr == ADDR_DBL) baud_rate[7:0]  <= bus.wdata;
         if (bus.ioaddr == ADDR_DBH) baud_rate[12:8] <= bus.wdata[4:0];
      end
   end

   // Set-dominant over the status-write clear.
   always_ff @(posedge clk) begin
      if (rst)                                      overrun <= 1'b0;
      else if (drop)                                overrun <= 1'b1;
      else if (wr_en && bus.ioaddr == ADDR_STAT)    overrun <= 1'b0;
   end

   always_comb begin
      bus.rdata = '0;
      if (rd_en) begin
         case (bus.ioaddr)
            ADDR_RXD:  bus.rdata = fifo_empty ? 8'h00 : fifo_dout;
            ADDR_STAT: bus.rdata = pack_status(overrun, 5'(fifo_count));
            ADDR_DBL:  bus.rdata = baud_rate[7:0];
            ADDR_DBH:  bus.rdata = {3'b000, baud_rate[12:8]};
            default:   bus.rdata = '0;
         endcase
      end
   end

   assign bus.rda = ~fifo_empty;

endmodule

// File: tb/tb_spart_rx_intf.sv
module tb_spart_rx_intf;

   localparam int unsigned DEPTH    = 8;
   localparam logic [12:0] BAUD_DEF = 13'd5208;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rdy = 1'b0;
   logic        clr_rdy;
   logic [12:0] baud_rate;
   logic        overrun;

   spart_rx_intf_if bus();

   spart_rx_intf #(
      .DEPTH        (DEPTH),
      .BAUD_DEFAULT (BAUD_DEF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .rx_data   (rx_data),
      .rdy       (rdy),
      .clr_rdy   (clr_rdy),
      .baud_rate (baud_rate),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   string       phase = "init";

   // Reference model: queue of bytes, sticky flag, divisor, last sampled rdy.
   logic [7:0]  m_q[$];
   logic        m_ovr;
   logic [12:0] m_baud;
   logic        m_rdy_prev;
   logic        m_clr;

   logic [7:0]  last_rdata;
   logic        last_clr;
   logic        last_rda;
   logic [12:0] last_baud;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_rdata(input logic cs, input logic rw, input logic [1:0] a);
      logic [4:0] n;
      if (!(cs && rw)) return 8'h00;
      n = 5'(m_q.size());
      case (a)
         2'd0:    return (m_q.size() > 0) ? m_q[0] : 8'h00;
         2'd1:    return {2'b00, m_ovr, n};
         2'd2:    return m_baud[7:0];
         default: return {3'b000, m_baud[12:8]};
      endcase
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_ovr      = 1'b0;
      m_baud     = BAUD_DEF;
      m_rdy_prev = 1'b0;
      m_clr      = 1'b0;
   endtask

   // One bus cycle: drive, check settled outputs, clock, advance the model.
   task automatic cycle(input logic cs, input logic rw, input logic [1:0] a,
                        input logic [7:0] wd, input logic r, input logic [7:0] rd);
      logic cap, pop, drop, stat_wr;
      bus.iocs   = cs;
      bus.iorw   = rw;
      bus.ioaddr = a;
      bus.wdata  = wd;
      rdy        = r;
      rx_data    = rd;
      #1;
      check("rdata",   bus.rdata, exp_rdata(cs, rw, a));
      check("rda",     bus.rda,   m_q.size() != 0);
      check("clr_rdy", clr_rdy,   m_clr);
      check("baud",    baud_rate, m_baud);
      check("overrun", overrun,   m_ovr);
      last_rdata = bus.rdata;
      last_clr   = clr_rdy;
      last_rda   = bus.rda;
      last_baud  = baud_rate;
      @(posedge clk);
      // A byte is taken on every rising edge of sampled rdy.
      cap     = r && !m_rdy_prev;
      pop     = cs && rw && a == 2'd0 && m_q.size() > 0;
      stat_wr = cs && !rw && a == 2'd1;
      if (pop) void'(m_q.pop_front());
      drop = cap && (m_q.size() >= DEPTH);
      if (cap && !drop) m_q.push_back(rd);
      if (drop)         m_ovr = 1'b1;
      else if (stat_wr) m_ovr = 1'b0;
      if (cs && !rw && a == 2'd2) m_baud[7:0]  = wd;
      if (cs && !rw && a == 2'd3) m_baud[12:8] = wd[4:0];
      m_clr      = cap;
      m_rdy_prev = r;
      #1;
   endtask

   task automatic do_reset(input logic r, input logic [7:0] rd);
      rst        = 1'b1;
      bus.iocs   = 1'b0;
      bus.iorw   = 1'b0;
      bus.ioaddr = 2'd0;
      bus.wdata  = 8'h00;
      rdy        = r;
      rx_data    = rd;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   task automatic idle(input logic r, input logic [7:0] rd);
      cycle(1'b0, 1'b0, 2'd0, 8'h00, r, rd);
   endtask

   task automatic rd_reg(input logic [1:0] a);
      cycle(1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      cycle(1'b1, 1'b0, a, d, 1'b0, 8'h00);
   endtask

   initial begin
      logic r_cur;
      bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'd0; bus.wdata = 8'h00;
      model_reset();
      @(posedge clk);
      #1;

      phase = "reset";
      do_reset(1'b0, 8'h00);
      rd_reg(2'd2); check("dbl_const", last_rdata, 8'h58);
      rd_reg(2'd3); check("dbh_const", last_rdata, 8'h14);
      rd_reg(2'd1); check("stat_const", last_rdata, 8'h00);
      check("rda_const", last_rda, 1'b0);
      check("clr_const", last_clr, 1'b0);

      phase = "pulse";
      idle(1'b1, 8'hA5);
      idle(1'b0, 8'h00);
      check("clr_const", last_clr, 1'b1);
      check("rda_const", last_rda, 1'b1);
      rd_reg(2'd0); check("pop_const", last_rdata, 8'hA5);
      rd_reg(2'd0); check("empty_pop", last_rdata, 8'h00);
      check("rda_empty", last_rda, 1'b0);

      phase = "hold";
      for (int i = 0; i < 5; i++) idle(1'b1, 8'h3C);
      idle(1'b0, 8'h00);
      rd_reg(2'd1); check("stat_one", last_rdata, 8'h01);
      rd_reg(2'd0); check("pop_3c", last_rdata, 8'h3C);

      phase = "overflow";
      for (int i = 1; i <= 9; i++) begin
         idle(1'b1, 8'(i));
         idle(1'b0, 8'h00);
      end
      rd_reg(2'd1); check("stat_ovr", last_rdata, 8'h28);
      for (int i = 1; i <= 8; i++) begin
         rd_reg(2'd0); check("pop_seq", last_rdata, 8'(i));
      end
      wr_reg(2'd1, 8'hFF);
      rd_reg(2'd1); check("stat_clr", last_rdata, 8'h00);

      phase = "full_pop_push";
      for (int i = 0; i < 8; i++) begin
         idle(1'b1, 8'(8'h10 + i));
         idle(1'b0, 8'h00);
      end
      cycle(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 8'h77);
      check("pop_head", last_rdata, 8'h10);
      idle(1'b0, 8'h00);
      rd_reg(2'd1); check("stat_full", last_rdata, 8'h08);
      for (int i = 0; i < 8; i++) rd_reg(2'd0);
      check("last_77", last_rdata, 8'h77);

      phase = "baud_reset";
      wr_reg(2'd2, 8'hB2);
      wr_reg(2'd3, 8'hFF);
      idle(1'b0, 8'h00);
      check("baud_const", last_baud, 13'h1FB2);
      idle(1'b1, 8'h55);
      idle(1'b1, 8'h55);
      do_reset(1'b1, 8'h55);
      idle(1'b1, 8'h55);
      check("baud_rst", last_baud, 13'd5208);
      check("rda_rst", last_rda, 1'b0);
      idle(1'b0, 8'h00);
      check("recapture", last_rda, 1'b1);

      phase = "random";
      r_cur = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic cs, rw;
         logic [1:0] a;
         if ($urandom_range(0, 2) == 0) r_cur = ~r_cur;
         if ($urandom_range(0, 299) == 0) begin
            do_reset(r_cur, 8'($urandom));
         end else begin
            cs = $urandom_range(0, 1);
            rw = $urandom_range(0, 1);
            a  = 2'($urandom);
            // Keep pops sparse in the first half so the FIFO reaches full.
            if (i < 1500 && cs && rw && a == 2'd0 && $urandom_range(0, 3) != 0) cs = 1'b0;
            cycle(cs, rw, a, 8'($urandom), r_cur, 8'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
